// File: rtl/hazard_controller_if.sv
// hazard_controller_if
//   Bundles the pipeline-side hazard inputs and the controller's stall, flush,
//   forward and statistics outputs. clk and Reset stay plain ports on the
//   controller.
//   master : pipeline side. It drives the register/enable/memory status signals
//            and consumes the stall/flush/forward/counter outputs.
//   slave  : hazard_controller side.
//   CNT_W  : width of StallCount and the optional performance counters.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RsD, RtD;
    logic             BranchD;
    logic [4:0]       RsE, RtE;
    logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM;
    logic             MemAccessM;
    logic             DMemReadyM;

    logic             StallF, StallD, StallE, StallM;
    logic             FlushE, FlushW;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount;
    logic             MemErr;
    logic [CNT_W-1:0] LoadStallCnt, BranchStallCnt, MemWaitCnt;

    modport master (
        output RsD, RtD, BranchD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW,
               MemtoRegE, MemtoRegM, MemAccessM, DMemReadyM,
        input  StallF, StallD, StallE, StallM, FlushE, FlushW,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               StallCount, MemErr,
               LoadStallCnt, BranchStallCnt, MemWaitCnt
    );

    modport slave (
        input  RsD, RtD, BranchD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW,
               MemtoRegE, MemtoRegM, MemAccessM, DMemReadyM,
        output StallF, StallD, StallE, StallM, FlushE, FlushW,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               StallCount, MemErr,
               LoadStallCnt, BranchStallCnt, MemWaitCnt
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and stall sequencer for the 5-stage pipeline. It produces the
//   forwarding selects for the decode comparator and the execute ALU, and it
//   inserts load-use and branch-operand stalls. It freezes the whole pipeline
//   while a data-memory access is outstanding, and it aborts the wait after
//   MEM_TIMEOUT cycles, which sets the sticky MemErr flag.
// Ports:
//   clk    : pipeline clock. All state updates on the rising edge.
//   Reset  : asynchronous active-low reset. It also forces all
//            stall/flush/forward outputs to 0.
//   hz     : hazard_controller_if.slave. This carries the pipeline inputs and
//            the StallF/D/E/M, FlushE/W, ForwardAD/BD/AE/BE, StallCount,
//            MemErr, LoadStallCnt, BranchStallCnt and MemWaitCnt outputs.
// Parameters:
//   CNT_W       : counter width (saturating counters).
//   MEM_TIMEOUT : maximum consecutive wait cycles, 1..1023.
// Optional build macro:
//   HAZ_PERF_EN : enables LoadStallCnt/BranchStallCnt/MemWaitCnt. When it is
//                 undefined, those ports are tied to 0.
module hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic           clk,
    input logic           Reset,
    hazard_controller_if.slave hz
);
    localparam int WAIT_W = 10;

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ABORT} state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [WAIT_W:0]   wait_inc;
    logic              freeze;
    logic              memwait;
    logic              lwstall, brstall, run_stall;
    logic              rs_d_nz, rt_d_nz;
    logic [CNT_W-1:0]  stall_count;
    logic              mem_err;

    assign rs_d_nz = (hz.RsD != 5'd0);
    assign rt_d_nz = (hz.RtD != 5'd0);

    // Register 0 never matches. Because RtE/WriteReg must equal a non-zero
    // source register, checking the source side for zero is enough.
    assign lwstall = hz.MemtoRegE &&
                     ((rs_d_nz && hz.RtE == hz.RsD) || (rt_d_nz && hz.RtE == hz.RtD));

    assign brstall = hz.BranchD &&
                     ((hz.RegWriteE && ((rs_d_nz && hz.WriteRegE == hz.RsD) ||
                                        (rt_d_nz && hz.WriteRegE == hz.RtD))) ||
                      (hz.MemtoRegM && ((rs_d_nz && hz.WriteRegM == hz.RsD) ||
                                        (rt_d_nz && hz.WriteRegM == hz.RtD))));

    assign run_stall = lwstall || brstall;
    assign memwait   = hz.MemAccessM && !hz.DMemReadyM;
    assign wait_inc  = {1'b0, wait_cnt} + (WAIT_W+1)'(1);

    always_comb begin
        next_state = state;
        wait_nxt   = wait_cnt;
        freeze     = 1'b0;
        case (state)
            RUN: begin
                wait_nxt = '0;
                if (memwait) begin
                    freeze     = 1'b1;
                    // The entering edge is already the first wait edge.
                    next_state = (MEM_TIMEOUT <= 1) ? MEM_ABORT : MEM_WAIT;
                    wait_nxt   = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!hz.DMemReadyM) begin
                    freeze = 1'b1;
                    if (wait_inc >= (WAIT_W+1)'(MEM_TIMEOUT)) begin
                        next_state = MEM_ABORT;
                        wait_nxt   = '0;
                    end else begin
                        wait_nxt = wait_inc[WAIT_W-1:0];
                    end
                end else begin
                    next_state = RUN;
                    wait_nxt   = '0;
                end
            end
            MEM_ABORT: begin
                // One cycle with RUN rules and memwait ignored.
                next_state = RUN;
                wait_nxt   = '0;
            end
            default: begin
                next_state = RUN;
                wait_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
        end
    end

    // Outputs: freeze dominates the lw/br stall; everything is gated by reset.
    assign hz.StallF = Reset && (freeze || run_stall);
    assign hz.StallD = Reset && (freeze || run_stall);
    assign hz.FlushE = Reset && !freeze && run_stall;
    assign hz.StallE = Reset && freeze;
    assign hz.StallM = Reset && freeze;
    assign hz.FlushW = Reset && freeze;

    // Forwarding: M has priority over W.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (Reset) begin
            if (hz.RsE != 5'd0 && hz.RegWriteM && hz.RsE == hz.WriteRegM)
                hz.ForwardAE = 2'b10;
            else if (hz.RsE != 5'd0 && hz.RegWriteW && hz.RsE == hz.WriteRegW)
                hz.ForwardAE = 2'b01;
            if (hz.RtE != 5'd0 && hz.RegWriteM && hz.RtE == hz.WriteRegM)
                hz.ForwardBE = 2'b10;
            else if (hz.RtE != 5'd0 && hz.RegWriteW && hz.RtE == hz.WriteRegW)
                hz.ForwardBE = 2'b01;
        end
    end

    assign hz.ForwardAD = Reset && rs_d_nz && hz.RegWriteM && hz.RsD == hz.WriteRegM;
    assign hz.ForwardBD = Reset && rt_d_nz && hz.RegWriteM && hz.RtD == hz.WriteRegM;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            stall_count <= '0;
            mem_err     <= 1'b0;
        end else begin
            if (hz.StallF && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (next_state == MEM_ABORT)
                mem_err <= 1'b1;
        end
    end

    assign hz.StallCount = stall_count;
    assign hz.MemErr     = mem_err;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] load_cnt, branch_cnt, memw_cnt;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            load_cnt   <= '0;
            branch_cnt <= '0;
            memw_cnt   <= '0;
        end else begin
            if (!freeze && lwstall && load_cnt != '1)
                load_cnt <= load_cnt + CNT_W'(1);
            if (!freeze && brstall && !lwstall && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (freeze && memw_cnt != '1)
                memw_cnt <= memw_cnt + CNT_W'(1);
        end
    end

    assign hz.LoadStallCnt   = load_cnt;
    assign hz.BranchStallCnt = branch_cnt;
    assign hz.MemWaitCnt     = memw_cnt;
`else
    assign hz.LoadStallCnt   = '0;
    assign hz.BranchStallCnt = '0;
    assign hz.MemWaitCnt     = '0;
`endif

endmodule
